// File: rtl/ifft8_seq.sv
// ifft8_seq: sequential 8-point radix-2 DIT inverse FFT.
// Bins are loaded in bit-reversed order, transformed in place by one shared
// butterfly over 12 cycles, then streamed out scaled by 1/8.
module ifft8_seq #(
    parameter int W        = 32,
    parameter int TW_SCALE = 100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [2:0]   out_idx,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned NPTS  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned BF_W  = 4;
    localparam int unsigned WW    = 2 * W;

    localparam logic [BF_W-1:0] BF_LAST = BF_W'(11);

    // cos/sin(45 deg) at the decimal twiddle scale, rounded to nearest
    localparam int TW_HALF = (TW_SCALE * 7071 + 5000) / 10000;

    localparam logic signed [W-1:0]  TW_ONE = W'(TW_SCALE);
    localparam logic signed [W-1:0]  TW_H   = W'(TW_HALF);
    localparam logic signed [WW-1:0] TW_DIV = WW'(TW_SCALE);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_cnt;
    logic [BF_W-1:0]       r_bf;
    logic signed [W-1:0]   r_buf_re [NPTS];
    logic signed [W-1:0]   r_buf_im [NPTS];

    logic [IDX_W-1:0]      w_load_idx;
    logic [IDX_W-1:0]      w_top;
    logic [IDX_W-1:0]      w_bot;
    logic [1:0]            w_k;
    logic signed [W-1:0]   w_tw_c;
    logic signed [W-1:0]   w_tw_s;
    logic signed [W-1:0]   w_a_re;
    logic signed [W-1:0]   w_a_im;
    logic signed [W-1:0]   w_b_re;
    logic signed [W-1:0]   w_b_im;
    logic signed [WW-1:0]  w_bre_x;
    logic signed [WW-1:0]  w_bim_x;
    logic signed [WW-1:0]  w_c_x;
    logic signed [WW-1:0]  w_s_x;
    logic signed [WW-1:0]  w_num_re;
    logic signed [WW-1:0]  w_num_im;
    logic signed [WW-1:0]  w_q_re;
    logic signed [WW-1:0]  w_q_im;
    logic signed [W-1:0]   w_t_re;
    logic signed [W-1:0]   w_t_im;

    assign w_load_idx = {r_cnt[0], r_cnt[1], r_cnt[2]};

    // Butterfly operand addresses and twiddle index from stage/butterfly counter
    always_comb begin
        w_top = '0;
        w_bot = '0;
        w_k   = '0;
        case (r_bf[3:2])
            2'd0: begin
                w_top = {r_bf[1:0], 1'b0};
                w_bot = {r_bf[1:0], 1'b1};
            end
            2'd1: begin
                w_top = {r_bf[1], 1'b0, r_bf[0]};
                w_bot = {r_bf[1], 1'b1, r_bf[0]};
                w_k   = {r_bf[0], 1'b0};
            end
            2'd2: begin
                w_top = {1'b0, r_bf[1:0]};
                w_bot = {1'b1, r_bf[1:0]};
                w_k   = r_bf[1:0];
            end
            default: ;
        endcase
    end

    // Inverse twiddle ROM W^+k = (cos, sin)
    always_comb begin
        w_tw_c = TW_ONE;
        w_tw_s = '0;
        case (w_k)
            2'd0: begin w_tw_c = TW_ONE; w_tw_s = '0;     end
            2'd1: begin w_tw_c = TW_H;   w_tw_s = TW_H;   end
            2'd2: begin w_tw_c = '0;     w_tw_s = TW_ONE; end
            2'd3: begin w_tw_c = -TW_H;  w_tw_s = TW_H;   end
            default: ;
        endcase
    end

    // Complex twiddle multiply at double width, then scale back down
    always_comb begin
        w_a_re   = r_buf_re[w_top];
        w_a_im   = r_buf_im[w_top];
        w_b_re   = r_buf_re[w_bot];
        w_b_im   = r_buf_im[w_bot];
        w_bre_x  = {{W{w_b_re[W-1]}}, w_b_re};
        w_bim_x  = {{W{w_b_im[W-1]}}, w_b_im};
        w_c_x    = {{W{w_tw_c[W-1]}}, w_tw_c};
        w_s_x    = {{W{w_tw_s[W-1]}}, w_tw_s};
        w_num_re = w_bre_x * w_c_x - w_bim_x * w_s_x;
        w_num_im = w_bre_x * w_s_x + w_bim_x * w_c_x;
        // signed division truncates toward zero
        w_q_re   = w_num_re / TW_DIV;
        w_q_im   = w_num_im / TW_DIV;
        w_t_re   = w_q_re[W-1:0];
        w_t_im   = w_q_im[W-1:0];
    end

    // Frame FSM with load, in-place butterfly and unload datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_bf    <= '0;
            for (int i = 0; i < int'(NPTS); i++) begin
                r_buf_re[i] <= '0;
                r_buf_im[i] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_buf_re[w_load_idx] <= in_re;
                        r_buf_im[w_load_idx] <= in_im;
                        // wraps to zero on the 8th accept
                        r_cnt <= r_cnt + IDX_W'(1);
                        if (r_cnt == IDX_W'(7)) begin
                            r_state <= S_COMPUTE;
                            r_bf    <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_buf_re[w_top] <= w_a_re + w_t_re;
                    r_buf_im[w_top] <= w_a_im + w_t_im;
                    r_buf_re[w_bot] <= w_a_re - w_t_re;
                    r_buf_im[w_bot] <= w_a_im - w_t_im;
                    if (r_bf == BF_LAST) begin
                        r_bf    <= '0;
                        r_cnt   <= '0;
                        r_state <= S_UNLOAD;
                    end else begin
                        r_bf <= r_bf + BF_W'(1);
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + IDX_W'(1);
                        if (r_cnt == IDX_W'(7)) begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_cnt   <= '0;
                    r_bf    <= '0;
                end
            endcase
        end
    end

    // Control and data outputs decode from registered state, count and buffer
    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_UNLOAD);
    assign busy      = (r_state == S_COMPUTE) || (r_state == S_UNLOAD);
    assign out_idx   = r_cnt;
    assign out_last  = out_valid && (r_cnt == IDX_W'(7));
    assign out_re    = r_buf_re[r_cnt] >>> 3;
    assign out_im    = r_buf_im[r_cnt] >>> 3;

endmodule

// File: doc/ifft8_seq.md
# ifft8_seq

Sequential 8-point inverse FFT, radix-2 decimation-in-time, sharing one butterfly and one complex multiplier across 12 cycles. It is the return path of the combinational 8-point forward FFT. It accepts eight complex frequency bins serially and stores them in bit-reversed order. It computes in place using the same decimal twiddle scale (×100), then streams eight time-domain complex samples scaled by 1/8.

## Interface
Parameters:
- `W`, 32: sample width for real and imaginary parts, signed two's complement.
- `TW_SCALE`, 100: twiddle scale; the twiddle ROM holds round(100·cos) and round(100·sin).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input bin valid.
- `in_ready`  out  1  block accepts a bin (high only in LOAD).
- `in_re`, `in_im`  in  W  bin value X[k]; k is implied by arrival order 0..7.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts the sample.
- `out_re`, `out_im`  out  W  time sample x[n].
- `out_idx`  out  3  n of the current output.
- `out_last`  out  1  high with n=7.
- `busy`  out  1  high in COMPUTE or UNLOAD.

## Operation
- Storage: 8×(re,im) register buffer `buf[0..7]`. Counter `cnt` is 3 bits, with a 4-bit stage/butterfly counter.
- FSM states: LOAD, COMPUTE, UNLOAD.
- LOAD:
  - in_ready=1. On in_valid&in_ready, write `buf[bitrev3(cnt)]` ← (in_re,in_im) and increment cnt.
  - The 8th accept (cnt=7) goes to COMPUTE with cnt←0.
- COMPUTE: 12 cycles, one butterfly per cycle, stage s=0..2, j=0..3.
  - half = 1<<s; top = ((j>>s)<<(s+1)) | (j&(half-1)); bot = top+half; twiddle index k = (j&(half-1))<<(2-s).
  - Inverse twiddle W⁺ᵏ = (c,s): k0=(100,0), k1=(71,71), k2=(0,100), k3=(-71,71).
  - t_re = (b_re·c − b_im·s)/100 and t_im = (b_re·s + b_im·c)/100. Products use a 2W-bit signed intermediate; the division is signed and truncates toward zero; the result is truncated to W.
  - buf[top] ← a+t and buf[bot] ← a−t, both wrapping modulo 2^W with no saturation.
  - After s=2, j=3, go to UNLOAD with cnt←0.
- UNLOAD:
  - out_valid=1, out_re = buf[cnt].re>>>3 and out_im = buf[cnt].im>>>3 (arithmetic shift, floor), out_idx=cnt, out_last=(cnt==7).
  - On out_valid&out_ready, cnt increments. The handshake with cnt=7 goes to LOAD.
- in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.

## Timing
- Reset (rst_n low at a rising edge): state=LOAD, cnt=0, stage counter=0, buf cleared to 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_re=out_im=0, out_idx=0, out_last=0, busy=0.
  - Reset in COMPUTE or UNLOAD aborts the frame. No partial output follows, and the next frame starts fresh.
- Control outputs decode combinationally from the registered state and cnt. out_re, out_im and out_idx come from the registered buffer, with the >>>3 shift only as decode. They have no comb path from in_* or out_ready.
- Latency: the 8th input accept at edge E enters COMPUTE. Butterflies complete at edges E+1..E+12, and out_valid is high from after E+12. With out_ready held high, the 8 outputs take edges E+13..E+20, and in_ready is high after E+20. Throughput is 28 cycles per frame without stalls.
- Backpressure: out_re, out_im, out_idx and out_last are held stable while out_valid&!out_ready. Input gaps (in_valid low) only stretch LOAD.
- There is no overlap: no new frame is accepted until the last output handshake.

## Test plan
- Impulse: X[0]=(800,0), X[1..7]=0 → all eight outputs (100,0); out_last only at idx 7. First out_valid 12 cycles after the 8th accept.
- DC bin of ramp: X[k]=(80,0) for all k → x[0]=(80,0), x[1..7]=(0,0).
- Tone: X[1]=(800,0), others 0 → x[0..7] = (100,0),(71,71),(0,100),(-71,71),(-100,0),(-71,-71),(0,-100),(71,-71).
- Backpressure and gaps: random in_valid gaps, and out_ready low for 5 cycles at idx 3 → idx 3 held unchanged, sequence intact, no extra or lost samples, busy=1 throughout COMPUTE and UNLOAD.
- Reset mid-COMPUTE (cycle 6), then a new impulse frame → no out_valid from the aborted frame; the new frame gives all (100,0).
- Round trip: forward-transform x=(8,16,24,...,64) real, feed the result in → outputs within ±2 of the originals (decimal twiddle error).
